// File: rtl/glb_block_sink.sv
// glb_block_sink
//   Sink for length-prefixed block streams leaving a GLB read channel.
//   After a falling edge on flush it captures 1..MAX_BLOCKS blocks, each a
//   length header followed by that many payload words, into per-block
//   buffers that can be read back through a synchronous port.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             arm/abort; falling edge starts a capture
//   num_blocks        blocks to capture (clamped to 1..MAX_BLOCKS)
//   data, valid       incoming header/payload words
//   ready             registered sink ready
//   done              all requested blocks captured (sticky)
//   overflow          some header exceeded DEPTH (sticky)
//   cur_blk           block currently being filled
//   blk_len           received header of block rd_blk
//   rd_blk, rd_addr   readback select
//   rd_data           readback word, one cycle latency
`timescale 1ns/1ps
module glb_block_sink #(
  parameter int          DATA_WIDTH  = 16,
  parameter int          DEPTH       = 2048,
  parameter int          MAX_BLOCKS  = 2,
  parameter int          START_DELAY = 3,
  parameter int          STALL_MODE  = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int         ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int         BLK_W       = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [BLK_W:0]        num_blocks,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  done,
  output logic                  overflow,
  output logic [BLK_W-1:0]      cur_blk,
  output logic [DATA_WIDTH-1:0] blk_len,
  input  logic [BLK_W-1:0]      rd_blk,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int CNT_W  = DATA_WIDTH + 1;
  localparam int WCNT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [BLK_W:0]    NB_MAX  = (BLK_W + 1)'(MAX_BLOCKS);
  localparam logic [WCNT_W-1:0] WLAST   = WCNT_W'(START_DELAY - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HDR, S_BODY, S_NEXT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    flush_q;
  logic [BLK_W:0]          nb_q, nb_d;
  logic [BLK_W-1:0]        cur_q, cur_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic                    xfer, len_we, len_clr, mem_we;
  logic [DATA_WIDTH-1:0]   len_q [MAX_BLOCKS];
  logic [DATA_WIDTH-1:0]   mem   [MAX_BLOCKS][DEPTH];
  logic [DATA_WIDTH-1:0]   rd_data_q;

  function automatic logic [BLK_W:0] clamp_nb(input logic [BLK_W:0] n);
    if (n == '0)         return (BLK_W + 1)'(1);
    else if (n > NB_MAX) return NB_MAX;
    else                 return n;
  endfunction

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    state_d = state_q;
    nb_d    = nb_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    len_we  = 1'b0;
    len_clr = 1'b0;
    mem_we  = 1'b0;
    xfer    = ready_q && valid;
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      cur_d   = '0;
      len_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush_q && !flush) begin
            nb_d    = clamp_nb(num_blocks);
            cur_d   = '0;
            wcnt_d  = '0;
            done_d  = 1'b0;
            state_d = (START_DELAY == 0) ? S_HDR : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wcnt_q == WLAST) state_d = S_HDR;
          else                 wcnt_d  = wcnt_q + 1'b1;
        end
        S_HDR: begin
          if (xfer) begin
            len_we = 1'b1;
            cnt_d  = '0;
            if ({1'b0, data} > DEPTH_C) ovf_d = 1'b1;
            state_d = (data == '0) ? S_NEXT : S_BODY;
          end
        end
        S_BODY: begin
          if (xfer) begin
            // words past DEPTH are still accepted, just not stored
            mem_we = (cnt_q < DEPTH_C);
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == {1'b0, len_q[cur_q]} - CNT_W'(1)) state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          if ({1'b0, cur_q} == nb_q - 1'b1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = S_HDR;
          end
        end
        default: ;
      endcase
    end
    ready_d = (state_d == S_HDR || state_d == S_BODY) &&
              ((STALL_MODE == 0) ? 1'b1 : lfsr_d[0]);
  end

  always_ff @(posedge clk) begin
    flush_q <= flush;
    if (rst) begin
      state_q <= S_IDLE;
      nb_q    <= (BLK_W + 1)'(1);
      cur_q   <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      nb_q    <= nb_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      lfsr_q  <= lfsr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || len_clr) begin
      for (int i = 0; i < MAX_BLOCKS; i++) len_q[i] <= '0;
    end else if (len_we) begin
      len_q[cur_q] <= data;
    end
  end

  // buffer write / registered readback (read-before-write on collision)
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[cur_q][cnt_q[ADDR_W-1:0]] <= data;
    if ({1'b0, rd_blk} < NB_MAX) rd_data_q <= mem[rd_blk][rd_addr];
    else                         rd_data_q <= '0;
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign cur_blk  = cur_q;
  assign rd_data  = rd_data_q;
  assign blk_len  = ({1'b0, rd_blk} < NB_MAX) ? len_q[rd_blk] : '0;

endmodule

// File: tb/tb_glb_block_sink.sv
`timescale 1ns/1ps
module tb_glb_block_sink;
  localparam int SD = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_s [2];
  logic        valid_s [2];
  logic        ready_s [2];
  logic        done_s  [2];
  logic        ovf_s   [2];
  logic        cur_s   [2];
  logic        rd_blk_s[2];
  logic [1:0]  nb_s    [2];
  logic [15:0] data_s  [2];
  logic [15:0] len_s   [2];
  logic [15:0] rdd_s   [2];
  logic [3:0]  rd_addr_s[2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // A: DEPTH 4, no backpressure
  glb_block_sink #(.DATA_WIDTH(16), .DEPTH(4), .MAX_BLOCKS(2), .START_DELAY(SD),
                   .STALL_MODE(0), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_s[0]), .num_blocks(nb_s[0]),
    .data(data_s[0]), .valid(valid_s[0]), .ready(ready_s[0]), .done(done_s[0]),
    .overflow(ovf_s[0]), .cur_blk(cur_s[0]), .blk_len(len_s[0]),
    .rd_blk(rd_blk_s[0]), .rd_addr(rd_addr_s[0][1:0]), .rd_data(rdd_s[0]));

  // B: DEPTH 16, LFSR backpressure
  glb_block_sink #(.DATA_WIDTH(16), .DEPTH(16), .MAX_BLOCKS(2), .START_DELAY(SD),
                   .STALL_MODE(1), .LFSR_SEED(16'hACE1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_s[1]), .num_blocks(nb_s[1]),
    .data(data_s[1]), .valid(valid_s[1]), .ready(ready_s[1]), .done(done_s[1]),
    .overflow(ovf_s[1]), .cur_blk(cur_s[1]), .blk_len(len_s[1]),
    .rd_blk(rd_blk_s[1]), .rd_addr(rd_addr_s[1]), .rd_data(rdd_s[1]));

  typedef struct {
    int nb; int len0; int len1;
    int base0; int step0; int base1; int step1;
    int exp_nblk; bit exp_ovf;
  } vec_t;

  vec_t        tbl[6];
  int          blen[2];
  logic [15:0] wds[2][32];
  logic [15:0] sq[$];
  bit          lastq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int clampm(input int nb);
    if (nb == 0) return 1;
    if (nb > 2) return 2;
    return nb;
  endfunction

  task automatic build(input int nbe);
    sq.delete(); lastq.delete();
    for (int b = 0; b < nbe; b++) begin
      sq.push_back(16'(blen[b])); lastq.push_back(blen[b] == 0);
      for (int k = 0; k < blen[b]; k++) begin
        sq.push_back(wds[b][k]); lastq.push_back(k == blen[b] - 1);
      end
    end
  endtask

  // called at a negedge; returns at the negedge after posedge SD+1
  task automatic start_capture(input int d, input int nb, input bit chk_timing);
    flush_s[d] = 1'b1; nb_s[d] = 2'(nb);
    @(negedge clk);
    flush_s[d] = 1'b0;
    for (int k = 1; k <= SD; k++) begin
      @(negedge clk);
      if (chk_timing) chk("wait_ready_low", ready_s[d], 0);
    end
    @(negedge clk);
    if (chk_timing) chk("first_ready", ready_s[d], 1);
  endtask

  task automatic send_stream(input int d, input int gap_pct, input int limit);
    int idx, sent, budget;
    bit bubble, x;
    idx = 0; sent = 0; budget = 0; bubble = 0;
    while (idx < sq.size() && sent < limit) begin
      if (bubble) begin chk("next_bubble_ready", ready_s[d], 0); bubble = 0; end
      valid_s[d] = ($urandom_range(99) >= gap_pct);
      data_s[d]  = valid_s[d] ? sq[idx] : 16'($urandom);
      x = ready_s[d] && valid_s[d];
      @(posedge clk);
      if (x) begin
        if (lastq[idx] && idx != sq.size() - 1) bubble = 1;
        idx++; sent++;
      end
      @(negedge clk);
      budget++;
      if (budget > 3000) begin
        tests++; fails++;
        $display("FAIL send_timeout: got %0d words expected %0d", idx, sq.size());
        break;
      end
    end
    valid_s[d] = 1'b0;
  endtask

  task automatic finish_capture(input int d);
    chk("bubble_before_done_ready", ready_s[d], 0);
    chk("done_not_yet", done_s[d], 0);
    @(negedge clk);
    chk("done", done_s[d], 1);
    chk("done_ready_low", ready_s[d], 0);
  endtask

  task automatic rd(input int d, input int b, input int a, output logic [15:0] v);
    rd_blk_s[d] = b[0]; rd_addr_s[d] = a[3:0];
    @(negedge clk);
    v = rdd_s[d];
  endtask

  task automatic getlen(input int d, input int b, output logic [15:0] v);
    rd_blk_s[d] = b[0];
    #1;
    v = len_s[d];
  endtask

  // checks lengths, overflow, cur_blk and buffer contents from blen/wds
  task automatic check_result(input int d, input int nbe, input int depth, input bit eovf);
    logic [15:0] v;
    chk("overflow", ovf_s[d], 32'(eovf));
    chk("cur_blk", cur_s[d], 32'(nbe - 1));
    for (int b = 0; b < nbe; b++) begin
      getlen(d, b, v);
      chk("blk_len", v, 32'(blen[b]));
      for (int k = 0; k < blen[b] && k < depth; k++) begin
        rd(d, b, k, v);
        chk("rd_data", v, 32'(wds[b][k]));
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    int nbe;
    bit eovf;

    tbl[0] = '{1, 4, 0, 'h11, 'h11, 0,    0, 1, 1'b0};
    tbl[1] = '{2, 0, 2, 0,    0,     'hA, 1, 2, 1'b0};
    tbl[2] = '{1, 6, 0, 1,    1,     0,   0, 1, 1'b1};
    tbl[3] = '{0, 3, 0, 'h30, 1,     0,   0, 1, 1'b0};
    tbl[4] = '{3, 2, 3, 'h40, 1,     'h50,1, 2, 1'b0};
    tbl[5] = '{2, 4, 5, 'hC1, 1,     'h70,1, 2, 1'b1};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      flush_s[d] = 0; valid_s[d] = 0; nb_s[d] = 1; data_s[d] = 0;
      rd_blk_s[d] = 0; rd_addr_s[d] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", ready_s[d], 0);
      chk("rst_done", done_s[d], 0);
      chk("rst_overflow", ovf_s[d], 0);
      chk("rst_cur_blk", cur_s[d], 0);
      getlen(d, 1, v);
      chk("rst_blk_len", v, 0);
    end
    @(negedge clk);

    // table-driven captures on the DEPTH=4 instance
    for (int i = 0; i < 6; i++) begin
      blen[0] = tbl[i].len0; blen[1] = tbl[i].len1;
      for (int k = 0; k < 32; k++) begin
        wds[0][k] = 16'(tbl[i].base0 + k * tbl[i].step0);
        wds[1][k] = 16'(tbl[i].base1 + k * tbl[i].step1);
      end
      start_capture(0, tbl[i].nb, 1'b1);
      build(tbl[i].exp_nblk);
      send_stream(0, (i == 0) ? 0 : 30, 1000);
      finish_capture(0);
      check_result(0, tbl[i].exp_nblk, 4, tbl[i].exp_ovf);
    end

    // reset mid-capture: block0 currently C1..C4
    blen[0] = 5;
    for (int k = 0; k < 5; k++) wds[0][k] = 16'h51 + 16'(k);
    start_capture(0, 1, 1'b1);
    build(1);
    send_stream(0, 0, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", ready_s[0], 0);
    chk("rst_mid_done", done_s[0], 0);
    chk("rst_mid_cur_blk", cur_s[0], 0);
    getlen(0, 0, v);
    chk("rst_mid_blk_len", v, 0);
    for (int k = 0; k < 6; k++) begin
      valid_s[0] = 1'b1; data_s[0] = 16'hEE;
      @(negedge clk);
      chk("rst_idle_ready", ready_s[0], 0);
    end
    valid_s[0] = 1'b0;
    rd(0, 0, 0, v); chk("rst_buf0", v, 'h51);
    rd(0, 0, 1, v); chk("rst_buf1", v, 'h52);
    rd(0, 0, 2, v); chk("rst_buf2", v, 'hC3);
    rd(0, 0, 3, v); chk("rst_buf3", v, 'hC4);
    // num_blocks=0 after reset captures one block
    blen[0] = 2; wds[0][0] = 16'h61; wds[0][1] = 16'h62;
    start_capture(0, 0, 1'b1);
    build(1);
    send_stream(0, 20, 1000);
    finish_capture(0);
    check_result(0, 1, 4, 1'b0);

    // abort during BODY with overflow pending
    blen[0] = 6;
    for (int k = 0; k < 6; k++) wds[0][k] = 16'h91 + 16'(k);
    start_capture(0, 1, 1'b1);
    build(1);
    send_stream(0, 0, 3);
    chk("abort_pre_overflow", ovf_s[0], 1);
    chk("abort_pre_ready", ready_s[0], 1);
    flush_s[0] = 1'b1;
    @(negedge clk);
    chk("abort_ready", ready_s[0], 0);
    chk("abort_done", done_s[0], 0);
    chk("abort_overflow", ovf_s[0], 0);
    getlen(0, 0, v);
    chk("abort_blk_len", v, 0);
    blen[0] = 1; wds[0][0] = 16'h7;
    start_capture(0, 1, 1'b1);
    build(1);
    send_stream(0, 0, 1000);
    finish_capture(0);
    check_result(0, 1, 4, 1'b0);
    rd(0, 0, 1, v); chk("abort_buf1", v, 'h92);

    // backpressured instance: fixed 3+5 case, then random captures
    for (int it = 0; it < 16; it++) begin
      int nb;
      if (it == 0) begin
        nb = 2; blen[0] = 3; blen[1] = 5;
      end else begin
        nb = $urandom_range(0, 3);
        blen[0] = $urandom_range(0, 20); blen[1] = $urandom_range(0, 20);
      end
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < 32; k++) wds[b][k] = 16'($urandom);
      nbe  = clampm(nb);
      eovf = 1'b0;
      for (int b = 0; b < nbe; b++) if (blen[b] > 16) eovf = 1'b1;
      start_capture(1, nb, 1'b0);
      build(nbe);
      send_stream(1, 40, 1000);
      finish_capture(1);
      check_result(1, nbe, 16, eovf);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/glb_block_sink.md
Name: glb_block_sink

Overview:
- Synthesizable, parametrised sink for length-prefixed block streams leaving a GLB read channel; the next generation of the testbench-only GLB read capture.
- Accepts 1..MAX_BLOCKS blocks over ready/valid. Each block is a length header followed by that many data words, stored into per-block buffers.
- Provides optional pseudo-random backpressure, overflow detection and a synchronous readback port, so benches check results in-sim instead of through file dumps.

Parameters:
- DATA_WIDTH, 16: width of header and payload words.
- DEPTH, 2048: words per block buffer; ADDR_W = $clog2(DEPTH).
- MAX_BLOCKS, 2: number of block buffers; BLK_W = $clog2(MAX_BLOCKS) (minimum 1).
- START_DELAY, 3: cycles after flush falls before ready may assert.
- STALL_MODE, 0: 0 = ready held high while receiving; 1 = ready gated by a 16-bit LFSR.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  arm/abort; a falling edge starts a capture
- num_blocks  in  BLK_W+1  blocks to capture, sampled on flush falling edge; 0 and values >MAX_BLOCKS are clamped (see Behaviour)
- data  in  DATA_WIDTH  header/payload word
- valid  in  1  data valid
- ready  out  1  sink ready (registered)
- done  out  1  all requested blocks captured (sticky until flush or rst)
- overflow  out  1  some header exceeded DEPTH (sticky)
- cur_blk  out  BLK_W  block currently being filled
- blk_len  out  DATA_WIDTH  header of block rd_blk, as received (unclamped)
- rd_blk  in  BLK_W  readback block select
- rd_addr  in  ADDR_W  readback address
- rd_data  out  DATA_WIDTH  buffer word; 1-cycle latency

Behaviour:
- Reset (sync, rst=1 at posedge):
  - Outputs: ready=0, done=0, overflow=0, cur_blk=0.
  - Internal: all lengths 0, LFSR=LFSR_SEED, state IDLE.
  - Buffer contents are not cleared. rd_data holds its value through reset.
  - rst mid-capture aborts immediately; nothing further is written.
- Transfer: a word transfers at a posedge with ready&&valid.
- ready is registered and depends only on state and LFSR, never combinationally on valid.
- FSM:
  - IDLE: ready=0. Waits for a flush 1->0 transition; flush is registered to detect the edge. On the edge, latch nb = clamp(num_blocks, 1, MAX_BLOCKS) and go to WAIT.
  - WAIT: count START_DELAY cycles with ready=0, then go to HDR.
  - HDR: on transfer, len[cur_blk]=data and word counter=0.
    - data==0: block is complete at once (go to NEXT).
    - Otherwise go to BODY.
  - BODY: on transfer, if counter<DEPTH, write buf[cur_blk][counter]=data. Counter increments on every transfer.
    - Words at counter>=DEPTH are accepted and dropped; overflow is set when the header is taken.
    - When counter reaches len-1 and that word transfers, go to NEXT.
  - NEXT: a single cycle with ready=0. If cur_blk==nb-1, go to DONE; otherwise cur_blk++ and go to HDR.
  - DONE: done=1, ready=0. Stays here until flush or rst.
- Flush:
  - flush=1 in any state except IDLE aborts: go to IDLE with ready=0; done, overflow, cur_blk and lengths cleared.
  - The following flush falling edge restarts the capture.
- Backpressure:
  - STALL_MODE=0: ready=1 in every cycle of HDR/BODY.
  - STALL_MODE=1: ready = lfsr[0] in HDR/BODY.
  - LFSR: x^16+x^14+x^13+x^11+1, Fibonacci, shifts every cycle after reset.
- Latency:
  - First possible transfer is START_DELAY+2 cycles after the flush falling edge (1 for edge detect, START_DELAY in WAIT, then ready registered).
  - One bubble cycle (NEXT) between blocks.
- Readback: rd_data = buf[rd_blk][rd_addr] registered. Read and write to the same location in one cycle returns old data. Out-of-range rd_blk returns 0.
- Width rules: len is compared as an unsigned DATA_WIDTH value; the counter is DATA_WIDTH+1 bits, so len=2^DATA_WIDTH-1 does not wrap.
- valid while ready=0 is ignored. data/valid need not be held stable by the source.

Test Plan:
- Single block, STALL_MODE=0, nb=1: after flush pulse, send header 4 and words 0x11,0x22,0x33,0x44 with valid always high -> first ready exactly START_DELAY+2 cycles after flush fall; done=1 two cycles after last transfer; readback addr0..3 = 0x11..0x44; blk_len=4.
- Two blocks, STALL_MODE=1: headers 3 and 5 with random valid gaps -> each word stored exactly once; ready low for the NEXT bubble; done only after 8th payload word; overflow=0.
- Zero-length block: nb=2, headers 0 then 2 (0xA,0xB) -> block0 len 0, block1 holds 0xA,0xB; done=1.
- Overflow with DEPTH=4: header 6, words 1..6 -> all 6 accepted (ready not held low), buf = 1,2,3,4, overflow=1, blk_len=6, done=1.
- Abort: flush=1 during BODY after 2 of 5 words -> ready=0 next cycle, done/overflow/blk_len cleared. A new flush fall with header 1, word 0x7 -> done=1 and buf0[0]=0x7.
- Reset mid-capture: rst=1 for one cycle in BODY -> ready=0, state IDLE. Further valid words are not written. num_blocks=0 at the next flush is clamped to 1 capture.
